qnigma_avg: RTL and testbench
=============================

Name: qnigma_avg

Overview:
- Streaming decimating averager: accepts one W-bit unsigned sample per `in_val` cycle.
- Accumulates 2**N samples serially, then emits the block sum and block mean with a one-cycle `out_val` strobe.
- Serial, time-domain counterpart of the parallel adder tree. Sits on the producer side of ADC/counter sample streams, feeding decimated results downstream.

Parameters:
- W, 8, sample width in bits (unsigned).
- N, 4, log2 of block length; block = 2**N samples; legal range 1..16.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous abort: discard the partial block.
- in_val  input  1  sample qualifier; no backpressure, every asserted cycle is consumed.
- in  input  W  sample value.
- out_val  output  1  one-cycle strobe: block complete.
- sum  output  W+N  block sum; held until the next strobe.
- avg  output  W  block mean; held until the next strobe.
- fill  output  N  samples accumulated in the current partial block.

Behaviour:
- Reset (async assert, sync release):
  - acc = 0, cnt = 0, state = EMPTY.
  - out_val = 0, sum = 0, avg = 0, fill = 0.
- State machine:
  - EMPTY: cnt == 0, acc == 0. An `in_val` cycle moves to FILL with acc = in and cnt = 1.
  - If N is such that 2**N == 1 it is illegal; N >= 1 guarantees at least 2 samples.
  - FILL, non-final sample (`in_val` with cnt < 2**N-1): acc += in, cnt += 1.
  - FILL, final sample (`in_val` with cnt == 2**N-1):
    - sum <= acc + in; avg <= derived from that value.
    - out_val <= 1 on the next cycle; acc <= 0, cnt <= 0, state = EMPTY.
- Latency: out_val rises exactly 1 cycle after the clock edge that accepts the 2**N-th sample.
- Back-to-back: an `in_val` on the cycle out_val is high is sample 1 of the next block; no dead cycle. Sustained 100% throughput.
- Arithmetic:
  - acc is W+N bits and cannot overflow; max = 2**N*(2**W-1).
  - avg = sum >> N (truncating) by default.
- fill = cnt; it wraps to 0 on block completion.
- out_val is a pulse: deasserted on every cycle it is not set.
- clr:
  - Discards acc/cnt and returns to EMPTY; sum/avg keep their last values; no out_val.
  - clr together with `in_val`: clr takes priority for the old block, and the concurrent sample becomes sample 1 of the new block (acc = in, cnt = 1).
  - clr on the final-sample cycle: block is discarded, no strobe, the sample starts a new block.
- `in_val` low: state frozen, no timeout.
- Reset mid-block: partial block lost, outputs cleared immediately (async).

Optional Feature:
- Macro: QNIGMA_AVG_ROUND_EN.
- Defined: avg = (sum + 2**(N-1)) >> N, i.e. round-half-up.
  - Intermediate fits in W+N bits; max sum + 2**(N-1) < 2**(W+N).
  - Result saturates naturally at 2**W-1, so no extra saturation logic is needed.
- Undefined: avg = sum >> N (truncate toward zero).
- sum, out_val and latency are identical in both builds.

Decomposition:
- Package qnigma_avg_pkg holds:
  - typedef enum {EMPTY, FILL} for the state;
  - localparam function `blk_len(N) = 2**N`;
  - rounding-offset constant helper.
- One sub-module: qnigma_avg_div. It is combinational and computes the W-bit mean from the (W+N)-bit sum, truncating or rounding under QNIGMA_AVG_ROUND_EN. It is registered by the parent.

Test Plan:
- W=8, N=2; feed 10,20,30,41 on consecutive cycles:
  - out_val 1 cycle after sample 4, sum = 101.
  - avg = 25 (truncate) / 25 (round, 101+2=103>>2).
  - fill sequence 1,2,3,0.
- W=8, N=4; 16 samples of 255 with gaps of random `in_val`-low cycles: sum = 4080, avg = 255 in both builds, exactly one strobe.
- N=2, samples 1,1,1,3 (sum 6): avg = 1 truncate, 2 with QNIGMA_AVG_ROUND_EN.
- Back-to-back: 3 blocks of continuous `in_val` (N=2, values 1..12):
  - strobes on cycles 5, 9, 13;
  - sums 10, 26, 42;
  - no sample lost.
- clr after 2 samples, then clr coincident with `in_val`=7, then samples 1,1,1:
  - single strobe with sum = 10;
  - sum/avg unchanged across the clr cycles.
- Assert rst asynchronously mid-block (between clock edges):
  - all outputs 0 immediately.
  - After release, a fresh 4-sample block produces the correct sum with no residue.

Source files
------------

// File: rtl/qnigma_avg_pkg.sv
// Shared types and helpers for the qnigma_avg decimating averager.
package qnigma_avg_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FILL  = 1'b1
    } state_t;

    function automatic int unsigned blk_len(input int unsigned n);
        return 32'd1 << n;
    endfunction

    // Half of one LSB of the mean, added before the shift when rounding
    function automatic int unsigned rnd_off(input int unsigned n);
        return (n == 0) ? 32'd0 : (32'd1 << (n - 1));
    endfunction

endpackage

// File: rtl/qnigma_avg_div.sv
// Combinational mean from block sum: sum >> N, or round-half-up when
// QNIGMA_AVG_ROUND_EN is defined.
module qnigma_avg_div
    import qnigma_avg_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic [W+N-1:0] sum,
    output logic [W-1:0]   avg
);

    logic [W+N-1:0] biased;

`ifdef QNIGMA_AVG_ROUND_EN
    localparam logic [W+N-1:0] RND = (W+N)'(rnd_off(N));
    // Cannot overflow: the largest sum is 2**N below the word limit
    assign biased = sum + RND;
`else
    assign biased = sum;
`endif

    assign avg = W'(biased >> N);

endmodule

// File: rtl/qnigma_avg.sv
// Streaming averager: accumulates 2**N samples, strobes block sum and mean.
// Build option: QNIGMA_AVG_ROUND_EN selects round-half-up mean.
//
//   state | meaning
//   EMPTY | no samples held, acc == 0, cnt == 0
//   FILL  | partial block, cnt samples accumulated in acc
module qnigma_avg
    import qnigma_avg_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           in_val,
    input  logic [W-1:0]   in,
    output logic           out_val,
    output logic [W+N-1:0] sum,
    output logic [W-1:0]   avg,
    output logic [N-1:0]   fill
);

    localparam logic [N-1:0] LAST = N'(blk_len(N) - 1);

    state_t         state;
    logic [W+N-1:0] acc;
    logic [N-1:0]   cnt;
    logic [W+N-1:0] smp;
    logic [W+N-1:0] acc_in;
    logic [W-1:0]   avg_next;

    assign smp    = {{N{1'b0}}, in};
    assign acc_in = acc + smp;
    assign fill   = cnt;

    qnigma_avg_div #(.W(W), .N(N)) u_div (
        .sum (acc_in),
        .avg (avg_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            acc     <= '0;
            cnt     <= '0;
            out_val <= 1'b0;
            sum     <= '0;
            avg     <= '0;
        end else begin
            out_val <= 1'b0;
            if (clr) begin
                // Old block is dropped; a concurrent sample opens the next one
                if (in_val) begin
                    state <= FILL;
                    acc   <= smp;
                    cnt   <= N'(1);
                end else begin
                    state <= EMPTY;
                    acc   <= '0;
                    cnt   <= '0;
                end
            end else if (in_val) begin
                case (state)
                    EMPTY: begin
                        state <= FILL;
                        acc   <= smp;
                        cnt   <= N'(1);
                    end
                    FILL: begin
                        if (cnt == LAST) begin
                            sum     <= acc_in;
                            avg     <= avg_next;
                            out_val <= 1'b1;
                            state   <= EMPTY;
                            acc     <= '0;
                            cnt     <= '0;
                        end else begin
                            acc <= acc_in;
                            cnt <= cnt + N'(1);
                        end
                    end
                    default: begin
                        state <= EMPTY;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qnigma_avg.sv
// Scoreboard bench for qnigma_avg: N=2 and N=4 instances against a block-queue model.
module tb_qnigma_avg;

    localparam int W  = 8;
    localparam int N2 = 2;
    localparam int N4 = 4;

    typedef struct {
        int due;
        int s;
        int a;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input longint act, input longint req);
        nchk++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int exp_avg(input int s, input int n);
`ifdef QNIGMA_AVG_ROUND_EN
        return (s + (1 << (n - 1))) / (1 << n);
`else
        return s / (1 << n);
`endif
    endfunction

    // ---------------- N=2 instance ----------------
    logic             rst2 = 1'b1, clr2 = 1'b0, in_val2 = 1'b0;
    logic [W-1:0]     in2 = '0;
    logic             out_val2;
    logic [W+N2-1:0]  sum2;
    logic [W-1:0]     avg2;
    logic [N2-1:0]    fill2;

    qnigma_avg #(.W(W), .N(N2)) dut2 (
        .clk(clk), .rst(rst2), .clr(clr2), .in_val(in_val2), .in(in2),
        .out_val(out_val2), .sum(sum2), .avg(avg2), .fill(fill2)
    );

    int   blk2[$];
    exp_t q2[$];
    int   fill_next2 = 0;
    int   exp_fill2 = 0;
    int   hold_sum2 = 0;
    int   hold_avg2 = 0;

    always @(posedge clk) exp_fill2 <= fill_next2;

    task automatic step2(input bit v, input int d, input bit c);
        exp_t e;
        int   s;
        in_val2 = v;
        in2     = W'(d);
        clr2    = c;
        if (c) blk2.delete();
        if (v) begin
            blk2.push_back(d);
            if (blk2.size() == (1 << N2)) begin
                s = 0;
                foreach (blk2[i]) s += blk2[i];
                e.due = cyc + 1;
                e.s   = s;
                e.a   = exp_avg(s, N2);
                q2.push_back(e);
                blk2.delete();
            end
        end
        fill_next2 = blk2.size();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst2) begin
            if (out_val2) begin
                if (q2.size() == 0) begin
                    chk("n2_unexpected_strobe", 1, 0);
                end else begin
                    e = q2.pop_front();
                    chk("n2_strobe_cycle", cyc, e.due);
                    chk("n2_sum", sum2, e.s);
                    chk("n2_avg", avg2, e.a);
                    hold_sum2 = e.s;
                    hold_avg2 = e.a;
                end
            end else if (q2.size() > 0 && q2[0].due <= cyc) begin
                e = q2.pop_front();
                chk("n2_missed_strobe_due", cyc, e.due + 1);
            end
            chk("n2_sum_hold", sum2, hold_sum2);
            chk("n2_avg_hold", avg2, hold_avg2);
            chk("n2_fill", fill2, exp_fill2);
        end
    end

    // ---------------- N=4 instance ----------------
    logic             rst4 = 1'b1, clr4 = 1'b0, in_val4 = 1'b0;
    logic [W-1:0]     in4 = '0;
    logic             out_val4;
    logic [W+N4-1:0]  sum4;
    logic [W-1:0]     avg4;
    logic [N4-1:0]    fill4;

    qnigma_avg #(.W(W), .N(N4)) dut4 (
        .clk(clk), .rst(rst4), .clr(clr4), .in_val(in_val4), .in(in4),
        .out_val(out_val4), .sum(sum4), .avg(avg4), .fill(fill4)
    );

    int   blk4[$];
    exp_t q4[$];

    task automatic step4(input bit v, input int d);
        exp_t e;
        int   s;
        in_val4 = v;
        in4     = W'(d);
        if (v) begin
            blk4.push_back(d);
            if (blk4.size() == (1 << N4)) begin
                s = 0;
                foreach (blk4[i]) s += blk4[i];
                e.due = cyc + 1;
                e.s   = s;
                e.a   = exp_avg(s, N4);
                q4.push_back(e);
                blk4.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst4) begin
            if (out_val4) begin
                if (q4.size() == 0) begin
                    chk("n4_unexpected_strobe", 1, 0);
                end else begin
                    e = q4.pop_front();
                    chk("n4_strobe_cycle", cyc, e.due);
                    chk("n4_sum", sum4, e.s);
                    chk("n4_avg", avg4, e.a);
                end
            end else if (q4.size() > 0 && q4[0].due <= cyc) begin
                e = q4.pop_front();
                chk("n4_missed_strobe_due", cyc, e.due + 1);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        #12;
        chk("rst_out_val", out_val2, 0);
        chk("rst_sum", sum2, 0);
        chk("rst_avg", avg2, 0);
        chk("rst_fill", fill2, 0);
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        rst4 = 1'b0;
        step2(0, 0, 0);

        // 10,20,30,41 -> sum 101, avg 25 in both builds
        step2(1, 10, 0); step2(1, 20, 0); step2(1, 30, 0); step2(1, 41, 0);
        step2(0, 0, 0);
        chk("blk1_sum_direct", sum2, 101);
        chk("blk1_avg_direct", avg2, 25);

        // 1,1,1,3 -> sum 6, avg 1 truncating / 2 rounding
        step2(1, 1, 0); step2(1, 1, 0); step2(1, 1, 0); step2(1, 3, 0);
        step2(0, 0, 0);
        chk("blk2_sum_direct", sum2, 6);
        chk("blk2_avg_direct", avg2, exp_avg(6, N2));

        // three back-to-back blocks 1..12
        for (int i = 1; i <= 12; i++) step2(1, i, 0);
        step2(0, 0, 0);
        chk("b2b_last_sum_direct", sum2, 42);

        // clr after 2 samples, clr with sample 7, then 1,1,1 -> sum 10
        step2(1, 5, 0); step2(1, 6, 0);
        step2(0, 0, 1);
        step2(1, 7, 1);
        step2(1, 1, 0); step2(1, 1, 0); step2(1, 1, 0);
        step2(0, 0, 0);
        chk("clr_sum_direct", sum2, 10);

        // clr on the final-sample cycle starts a new block with that sample
        step2(1, 1, 0); step2(1, 2, 0); step2(1, 3, 0);
        step2(1, 9, 1);
        step2(1, 1, 0); step2(1, 1, 0); step2(1, 1, 0);
        step2(0, 0, 0);
        chk("clr_final_sum_direct", sum2, 12);

        // N=4: 16 samples of 255 with random idle gaps
        for (int i = 0; i < 16; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) step4(0, 0);
            step4(1, 255);
        end
        step4(0, 0);
        step4(0, 0);
        chk("n4_sum_direct", sum4, 4080);
        chk("n4_avg_direct", avg4, 255);

        // randomized traffic on N=2
        for (int i = 0; i < 400; i++) begin
            step2($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
                  $urandom_range(0, 15) == 0);
        end
        step2(0, 0, 0);
        step2(0, 0, 0);

        // asynchronous reset in the middle of a block
        step2(1, 50, 0); step2(1, 60, 0);
        in_val2 = 1'b0;
        #3;
        rst2 = 1'b1;
        #1;
        chk("async_rst_out_val", out_val2, 0);
        chk("async_rst_sum", sum2, 0);
        chk("async_rst_avg", avg2, 0);
        chk("async_rst_fill", fill2, 0);
        blk2.delete();
        q2.delete();
        fill_next2 = 0;
        exp_fill2  = 0;
        hold_sum2  = 0;
        hold_avg2  = 0;
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        step2(0, 0, 0);
        step2(1, 4, 0); step2(1, 5, 0); step2(1, 6, 0); step2(1, 7, 0);
        step2(0, 0, 0);
        chk("post_rst_sum_direct", sum2, 22);

        step2(0, 0, 0);
        step2(0, 0, 0);
        chk("n2_pending_at_end", q2.size(), 0);
        chk("n4_pending_at_end", q4.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
